hazard_tag_pipe: RTL and testbench

- Producer side of the hazard-unit interface. Carries register-tag and write-control state down the E/M/W pipeline.
- Emits every Match_* comparison, plus the RegWrite/MemToReg qualifiers, that the hazard unit consumes.
- Consumes the hazard unit's StallD/FlushD/FlushE outputs to hold or bubble its own stage registers.
- Sits beside the datapath pipeline registers. Its inputs are decoded combinationally from InstrD.

---
 rtl/hazard_tag_pipe.sv | 177 +++++++++++++++++
 tb/tb_hazard_tag_pipe.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe: carries register tags and write-control bits down E/M/W and emits the Match_*
// comparisons the hazard unit consumes. Optional macro HAZARD_PC_EXCLUDE_EN masks R15 source matches.
module hazard_tag_pipe #(
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RA1D,
    input  logic [REG_W-1:0] RA2D,
    input  logic [REG_W-1:0] RA3D,
    input  logic [REG_W-1:0] RA0D,
    input  logic [REG_W-1:0] WA3D,
    input  logic [REG_W-1:0] WA4D,
    input  logic             RegWriteD,
    input  logic             RegWrite2D,
    input  logic             MemToRegD,
    input  logic             InstrValidF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             FlushE,
    output logic             Match_1E_M,
    output logic             Match_1E_W,
    output logic             Match_1E_M0,
    output logic             Match_1E_W0,
    output logic             Match_2E_M,
    output logic             Match_2E_W,
    output logic             Match_2E_M0,
    output logic             Match_2E_W0,
    output logic             Match_3E_M,
    output logic             Match_3E_W,
    output logic             Match_3E_M0,
    output logic             Match_3E_W0,
    output logic             Match_0E_M,
    output logic             Match_0E_W,
    output logic             Match_0E_M0,
    output logic             Match_0E_W0,
    output logic             Match_12D_E,
    output logic             RegWriteM,
    output logic             RegWriteW,
    output logic             RegWrite2M,
    output logic             RegWrite2W,
    output logic             MemToRegE
);

`ifdef HAZARD_PC_EXCLUDE_EN
    localparam logic [REG_W-1:0] PC_TAG = REG_W'(15);
`endif

    // PC reads come from the PC path (PC+8), so an R15 source never forwards.
    function automatic logic src_match(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
`ifdef HAZARD_PC_EXCLUDE_EN
        return (src == dst) && (src != PC_TAG);
`else
        return src == dst;
`endif
    endfunction

    logic             valid_d;

    logic [REG_W-1:0] ra0_e;
    logic [REG_W-1:0] ra1_e;
    logic [REG_W-1:0] ra2_e;
    logic [REG_W-1:0] ra3_e;
    logic [REG_W-1:0] wa3_e;
    logic [REG_W-1:0] wa4_e;
    logic             reg_write_e;
    logic             reg_write2_e;
    logic             mem_to_reg_e;

    logic [REG_W-1:0] wa3_m;
    logic [REG_W-1:0] wa4_m;
    logic             reg_write_m;
    logic             reg_write2_m;

    logic [REG_W-1:0] wa3_w;
    logic [REG_W-1:0] wa4_w;
    logic             reg_write_w;
    logic             reg_write2_w;

    // FlushD outranks StallD; StallD is an enable, so 0 means hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_d <= 1'b0;
        end else if (FlushD) begin
            valid_d <= 1'b0;
        end else if (StallD) begin
            valid_d <= InstrValidF;
        end
    end

    // E never holds: a flush with StallD=0 upstream is how the load-use bubble is formed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra0_e        <= '0;
            ra1_e        <= '0;
            ra2_e        <= '0;
            ra3_e        <= '0;
            wa3_e        <= '0;
            wa4_e        <= '0;
            reg_write_e  <= 1'b0;
            reg_write2_e <= 1'b0;
            mem_to_reg_e <= 1'b0;
        end else if (FlushE) begin
            ra0_e        <= '0;
            ra1_e        <= '0;
            ra2_e        <= '0;
            ra3_e        <= '0;
            wa3_e        <= '0;
            wa4_e        <= '0;
            reg_write_e  <= 1'b0;
            reg_write2_e <= 1'b0;
            mem_to_reg_e <= 1'b0;
        end else begin
            ra0_e        <= RA0D;
            ra1_e        <= RA1D;
            ra2_e        <= RA2D;
            ra3_e        <= RA3D;
            wa3_e        <= WA3D;
            wa4_e        <= WA4D;
            reg_write_e  <= RegWriteD & valid_d;
            reg_write2_e <= RegWrite2D & valid_d;
            mem_to_reg_e <= MemToRegD & valid_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wa3_m        <= '0;
            wa4_m        <= '0;
            reg_write_m  <= 1'b0;
            reg_write2_m <= 1'b0;
            wa3_w        <= '0;
            wa4_w        <= '0;
            reg_write_w  <= 1'b0;
            reg_write2_w <= 1'b0;
        end else begin
            wa3_m        <= wa3_e;
            wa4_m        <= wa4_e;
            reg_write_m  <= reg_write_e;
            reg_write2_m <= reg_write2_e;
            wa3_w        <= wa3_m;
            wa4_w        <= wa4_m;
            reg_write_w  <= reg_write_m;
            reg_write2_w <= reg_write2_m;
        end
    end

    // Raw tag equality; the hazard unit applies the RegWrite qualifiers itself.
    assign Match_1E_M  = src_match(ra1_e, wa3_m);
    assign Match_1E_W  = src_match(ra1_e, wa3_w);
    assign Match_1E_M0 = src_match(ra1_e, wa4_m);
    assign Match_1E_W0 = src_match(ra1_e, wa4_w);

    assign Match_2E_M  = src_match(ra2_e, wa3_m);
    assign Match_2E_W  = src_match(ra2_e, wa3_w);
    assign Match_2E_M0 = src_match(ra2_e, wa4_m);
    assign Match_2E_W0 = src_match(ra2_e, wa4_w);

    assign Match_3E_M  = src_match(ra3_e, wa3_m);
    assign Match_3E_W  = src_match(ra3_e, wa3_w);
    assign Match_3E_M0 = src_match(ra3_e, wa4_m);
    assign Match_3E_W0 = src_match(ra3_e, wa4_w);

    assign Match_0E_M  = src_match(ra0_e, wa3_m);
    assign Match_0E_W  = src_match(ra0_e, wa3_w);
    assign Match_0E_M0 = src_match(ra0_e, wa4_m);
    assign Match_0E_W0 = src_match(ra0_e, wa4_w);

    assign Match_12D_E = valid_d & (src_match(RA1D, wa3_e) | src_match(RA2D, wa3_e));

    assign RegWriteM   = reg_write_m;
    assign RegWriteW   = reg_write_w;
    assign RegWrite2M  = reg_write2_m;
    assign RegWrite2W  = reg_write2_w;
    assign MemToRegE   = mem_to_reg_e;

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// tb_hazard_tag_pipe: directed hazard scenarios plus randomized traffic against a record-shifting
// reference model of the D/E/M/W tag pipeline.
module tb_hazard_tag_pipe;

    logic       clk;
    logic       reset;
    logic [3:0] RA1D, RA2D, RA3D, RA0D, WA3D, WA4D;
    logic       RegWriteD, RegWrite2D, MemToRegD, InstrValidF;
    logic       StallD, FlushD, FlushE;
    logic       Match_1E_M, Match_1E_W, Match_1E_M0, Match_1E_W0;
    logic       Match_2E_M, Match_2E_W, Match_2E_M0, Match_2E_W0;
    logic       Match_3E_M, Match_3E_W, Match_3E_M0, Match_3E_W0;
    logic       Match_0E_M, Match_0E_W, Match_0E_M0, Match_0E_W0;
    logic       Match_12D_E, RegWriteM, RegWriteW, RegWrite2M, RegWrite2W, MemToRegE;

    hazard_tag_pipe #(.REG_W(4)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA3D(RA3D), .RA0D(RA0D), .WA3D(WA3D), .WA4D(WA4D),
        .RegWriteD(RegWriteD), .RegWrite2D(RegWrite2D), .MemToRegD(MemToRegD),
        .InstrValidF(InstrValidF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W), .Match_1E_M0(Match_1E_M0), .Match_1E_W0(Match_1E_W0),
        .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W), .Match_2E_M0(Match_2E_M0), .Match_2E_W0(Match_2E_W0),
        .Match_3E_M(Match_3E_M), .Match_3E_W(Match_3E_W), .Match_3E_M0(Match_3E_M0), .Match_3E_W0(Match_3E_W0),
        .Match_0E_M(Match_0E_M), .Match_0E_W(Match_0E_W), .Match_0E_M0(Match_0E_M0), .Match_0E_W0(Match_0E_W0),
        .Match_12D_E(Match_12D_E), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RegWrite2M(RegWrite2M), .RegWrite2W(RegWrite2W), .MemToRegE(MemToRegE)
    );

    logic [21:0] obs;
    assign obs = {Match_1E_M, Match_1E_W, Match_1E_M0, Match_1E_W0,
                  Match_2E_M, Match_2E_W, Match_2E_M0, Match_2E_W0,
                  Match_3E_M, Match_3E_W, Match_3E_M0, Match_3E_W0,
                  Match_0E_M, Match_0E_W, Match_0E_M0, Match_0E_W0,
                  Match_12D_E, RegWriteM, RegWriteW, RegWrite2M, RegWrite2W, MemToRegE};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0] ra0, ra1, ra2, ra3, wa3, wa4;
        logic       rw, rw2, m2r;
    } rec_t;

    rec_t        stage_q[$];   // [0]=E, [1]=M, [2]=W; each instruction record shifts one slot per clock
    logic        m_valid_d;
    logic [21:0] exp_q[$];
    logic [21:0] exp;
    int          checks;
    int          errors;

    function automatic logic pc_src(input logic [3:0] s);
`ifdef HAZARD_PC_EXCLUDE_EN
        return s == 4'd15;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] match4(input logic [3:0] s, input rec_t m, input rec_t w);
        if (pc_src(s)) return 4'b0000;
        return {s == m.wa3, s == w.wa3, s == m.wa4, s == w.wa4};
    endfunction

    function automatic logic [21:0] model_out();
        rec_t e, m, w;
        logic m12;
        e = stage_q[0];
        m = stage_q[1];
        w = stage_q[2];
        m12 = m_valid_d && ((RA1D == e.wa3 && !pc_src(RA1D)) || (RA2D == e.wa3 && !pc_src(RA2D)));
        return {match4(e.ra1, m, w), match4(e.ra2, m, w), match4(e.ra3, m, w), match4(e.ra0, m, w),
                m12, m.rw, w.rw, m.rw2, w.rw2, e.m2r};
    endfunction

    task automatic model_reset();
        stage_q.delete();
        for (int i = 0; i < 3; i++) stage_q.push_back('0);
        m_valid_d = 1'b0;
    endtask

    // ---------------- drivers ----------------
    task automatic clear_d();
        RA1D = 0; RA2D = 0; RA3D = 0; RA0D = 0; WA3D = 0; WA4D = 0;
        RegWriteD = 0; RegWrite2D = 0; MemToRegD = 0;
        InstrValidF = 1; StallD = 1; FlushD = 0; FlushE = 0;
    endtask

    function automatic logic [3:0] rand_tag();
        return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    task automatic drive_random();
        RA1D = rand_tag(); RA2D = rand_tag(); RA3D = rand_tag(); RA0D = rand_tag();
        WA3D = rand_tag(); WA4D = rand_tag();
        RegWriteD = 1'($urandom_range(0, 1)); RegWrite2D = 1'($urandom_range(0, 1));
        MemToRegD = 1'($urandom_range(0, 1)); InstrValidF = ($urandom_range(0, 4) != 0);
        StallD = ($urandom_range(0, 4) != 0); FlushD = ($urandom_range(0, 7) == 0);
        FlushE = ($urandom_range(0, 7) == 0);
    endtask

    // One clock: the model takes the inputs present before the edge; expected outputs are queued #1 after.
    task automatic tick();
        rec_t nxt, drop;
        logic nv;
        if (FlushE) nxt = '0;
        else nxt = '{ra0: RA0D, ra1: RA1D, ra2: RA2D, ra3: RA3D, wa3: WA3D, wa4: WA4D,
                     rw: RegWriteD & m_valid_d, rw2: RegWrite2D & m_valid_d, m2r: MemToRegD & m_valid_d};
        nv = FlushD ? 1'b0 : (StallD ? InstrValidF : m_valid_d);
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            stage_q.push_front(nxt);
            drop = stage_q.pop_back();
            m_valid_d = nv;
        end
        #1;
        exp_q.push_back(model_out());
    endtask

    // ---------------- scenarios ----------------
    // Tags all clear to 0, so the raw E-vs-M/W equalities read 1 in reset; the qualifiers read 0.
    task automatic test_reset();
        #2 reset = 1'b0;
        drive_random();
        #1;
        checks++;
        if (obs[5:0] !== 6'd0) begin
            errors++; $display("FAIL reset_async_qual: got %b expected 000000", obs[5:0]);
        end
        for (int i = 0; i < 3; i++) begin
            drive_random();
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL reset_hold_vec: got %h expected %h", obs, exp);
            end
            checks++;
            if (obs[5:0] !== 6'd0) begin
                errors++; $display("FAIL reset_hold_qual: got %b expected 000000", obs[5:0]);
            end
        end
        reset = 1'b1;
        clear_d();
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL reset_release_vec: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_alu_dependency();
        clear_d();
        tick(); exp = exp_q.pop_front();
        WA3D = 4'd1; RegWriteD = 1'b1; RA1D = 4'd0;
        tick(); exp = exp_q.pop_front();
        WA3D = 4'd7; RegWriteD = 1'b0; RA1D = 4'd1;
        tick(); exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL alu_m_vec: got %h expected %h", obs, exp);
        end
        checks++;
        if ({Match_1E_M, RegWriteM} !== 2'b11) begin
            errors++; $display("FAIL alu_m: got Match_1E_M=%b RegWriteM=%b expected 1 1", Match_1E_M, RegWriteM);
        end
        tick(); exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL alu_w_vec: got %h expected %h", obs, exp);
        end
        checks++;
        if ({Match_1E_W, RegWriteW, Match_1E_M} !== 3'b110) begin
            errors++; $display("FAIL alu_w: got W=%b RegWriteW=%b M=%b expected 1 1 0", Match_1E_W, RegWriteW, Match_1E_M);
        end
    endtask

    task automatic test_load_use();
        clear_d();
        tick(); exp = exp_q.pop_front();
        WA3D = 4'd2; MemToRegD = 1'b1; RegWriteD = 1'b1; RA1D = 4'd9; RA2D = 4'd9;
        tick(); exp = exp_q.pop_front();
        RA1D = 4'd0; RA2D = 4'd2; WA3D = 4'd8; MemToRegD = 1'b0; RegWriteD = 1'b1;
        #1;
        exp = model_out();
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL load_detect_vec: got %h expected %h", obs, exp);
        end
        checks++;
        if ({Match_12D_E, MemToRegE} !== 2'b11) begin
            errors++; $display("FAIL load_detect: got Match_12D_E=%b MemToRegE=%b expected 1 1", Match_12D_E, MemToRegE);
        end
        StallD = 1'b0; FlushE = 1'b1; InstrValidF = 1'b0;
        tick(); exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL load_bubble_vec: got %h expected %h", obs, exp);
        end
        // E tags are now 0 and RA1D=0, so Match_12D_E shows ValidD survived the stall.
        checks++;
        if ({MemToRegE, RegWriteM, Match_12D_E} !== 3'b011) begin
            errors++; $display("FAIL load_bubble: got MemToRegE=%b RegWriteM=%b Match_12D_E=%b expected 0 1 1",
                               MemToRegE, RegWriteM, Match_12D_E);
        end
        StallD = 1'b1; FlushE = 1'b0; InstrValidF = 1'b1;
        tick(); exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL load_resume_vec: got %h expected %h", obs, exp);
        end
        checks++;
        if (RegWriteM !== 1'b0) begin
            errors++; $display("FAIL load_resume_bubble: got RegWriteM=%b expected 0", RegWriteM);
        end
    endtask

    task automatic test_long_multiply();
        clear_d();
        tick(); exp = exp_q.pop_front();
        WA3D = 4'd4; WA4D = 4'd5; RegWriteD = 1'b1; RegWrite2D = 1'b1;
        tick(); exp = exp_q.pop_front();
        WA3D = 4'd0; WA4D = 4'd0; RegWriteD = 1'b0; RegWrite2D = 1'b0; RA0D = 4'd5;
        tick(); exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL mul_m0_vec: got %h expected %h", obs, exp);
        end
        checks++;
        if ({Match_0E_M0, RegWrite2M, Match_0E_M} !== 3'b110) begin
            errors++; $display("FAIL mul_m0: got M0=%b RegWrite2M=%b M=%b expected 1 1 0", Match_0E_M0, RegWrite2M, Match_0E_M);
        end
        tick(); exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL mul_w0_vec: got %h expected %h", obs, exp);
        end
        checks++;
        if ({Match_0E_W0, RegWrite2W} !== 2'b11) begin
            errors++; $display("FAIL mul_w0: got W0=%b RegWrite2W=%b expected 1 1", Match_0E_W0, RegWrite2W);
        end
    endtask

    task automatic test_flush();
        clear_d();
        tick(); exp = exp_q.pop_front();
        WA3D = 4'd6; RegWriteD = 1'b1; FlushD = 1'b1; FlushE = 1'b1; RA1D = 4'd0;
        tick(); exp = exp_q.pop_front();
        checks++;
        if ({Match_12D_E, MemToRegE} !== 2'b00) begin
            errors++; $display("FAIL flush_d_invalid: got Match_12D_E=%b MemToRegE=%b expected 0 0", Match_12D_E, MemToRegE);
        end
        FlushD = 1'b0; FlushE = 1'b0; StallD = 1'b0; RA1D = 4'd6;
        for (int i = 0; i < 2; i++) begin
            tick(); exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL flush_vec: got %h expected %h", obs, exp);
            end
            checks++;
            if ({RegWriteM, Match_12D_E} !== 2'b00) begin
                errors++; $display("FAIL flush_no_write: got RegWriteM=%b Match_12D_E=%b expected 0 0", RegWriteM, Match_12D_E);
            end
        end
    endtask

    task automatic test_pc_source();
        logic want;
`ifdef HAZARD_PC_EXCLUDE_EN
        want = 1'b0;
`else
        want = 1'b1;
`endif
        clear_d();
        tick(); exp = exp_q.pop_front();
        WA3D = 4'd15; RegWriteD = 1'b1;
        tick(); exp = exp_q.pop_front();
        WA3D = 4'd3; RegWriteD = 1'b0; RA1D = 4'd15;
        tick(); exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL pc_vec: got %h expected %h", obs, exp);
        end
        checks++;
        if (Match_1E_M !== want) begin
            errors++; $display("FAIL pc_match: got Match_1E_M=%b expected %b", Match_1E_M, want);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive_random();
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL random_vec cycle %0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        clear_d();
        WA3D = 4'd9; WA4D = 4'd10; RegWriteD = 1'b1; RegWrite2D = 1'b1; MemToRegD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); exp = exp_q.pop_front();
        end
        #2 reset = 1'b0;
        #1;
        model_reset();
        exp = model_out();
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL reset_mid_vec: got %h expected %h", obs, exp);
        end
        checks++;
        if (obs[5:0] !== 6'd0) begin
            errors++; $display("FAIL reset_mid_qual: got %b expected 000000", obs[5:0]);
        end
        tick(); exp = exp_q.pop_front();
        reset = 1'b1;
        tick(); exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL reset_mid_release_vec: got %h expected %h", obs, exp);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        clear_d();
        model_reset();
        test_reset();
        test_alu_dependency();
        test_load_use();
        test_long_multiply();
        test_flush();
        test_pc_source();
        test_random();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
